// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, core instruction stream, redirect.
// The master side is the fetch unit; the slave side is the memory/core environment.
interface fetch_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready, redirect, redirect_pc,
    output misalign_err
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready, redirect, redirect_pc,
    input  misalign_err
  );
endinterface

// File: rtl/fetch_unit.sv
// In-order instruction fetch: credit-limited word requests, PC-tagged response queue, redirect flush.
// Response-to-inst_valid latency 1 cycle; responses never back-pressured, requests throttled by credit.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 4
) (
  input  logic clk,
  input  logic rst,
  fetch_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(DEPTH + 1) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUT);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [TW-1:0] TLAST   = TW'(MAX_OUT - 1);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_out, r_drop, r_cnt;
  logic [CW-1:0] w_out_nxt, w_drop_nxt;
  logic [31:0]   r_q_dat [DEPTH];
  logic [31:0]   r_q_pc  [DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [31:0]   r_tag   [MAX_OUT];
  logic [TW-1:0] r_t_rd, r_t_wr;
  logic [31:0]   r_hold_dat, r_hold_pc;
  logic          r_mis;
  logic          w_req_vld, w_acc, w_rsp, w_keep, w_pop, w_redir;
  logic [CW-1:0] w_keep_c, w_pop_c;

  assign w_redir   = bus.redirect;
  // Credit counts in-flight requests (including ones to be dropped) so a kept response always has a slot.
  assign w_req_vld = (r_state != S_BOOT) && ((r_out + r_cnt) < DEPTH_C) &&
                     (r_out < MAXO_C) && !w_redir;
  assign w_acc     = w_req_vld && bus.imem_req_ready;
  assign w_rsp     = bus.imem_rsp_valid;
  assign w_keep    = w_rsp && (r_drop == '0) && !w_redir;
  assign w_pop     = (r_cnt != '0) && bus.inst_ready && !w_redir;
  assign w_keep_c  = {{(CW-1){1'b0}}, w_keep};
  assign w_pop_c   = {{(CW-1){1'b0}}, w_pop};

  always_comb begin
    w_out_nxt   = r_out + {{(CW-1){1'b0}}, w_acc} - {{(CW-1){1'b0}}, w_rsp};
    w_drop_nxt  = r_drop;
    w_state_nxt = r_state;
    if (w_redir) begin
      w_drop_nxt = w_out_nxt;
    end else if (w_rsp && (r_drop != '0)) begin
      w_drop_nxt = r_drop - ONE_C;
    end
    case (r_state)
      S_BOOT:  w_state_nxt = S_RUN;
      default: w_state_nxt = (w_drop_nxt != '0) ? S_FLUSH : S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_BOOT;
      r_fetch_pc <= RESET_PC;
      r_out      <= '0;
      r_drop     <= '0;
      r_cnt      <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_t_rd     <= '0;
      r_t_wr     <= '0;
      r_hold_dat <= '0;
      r_hold_pc  <= '0;
      r_mis      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_drop  <= w_drop_nxt;
      if (w_acc) r_t_wr <= (r_t_wr == TLAST) ? '0 : r_t_wr + TW'(1);
      if (w_rsp) r_t_rd <= (r_t_rd == TLAST) ? '0 : r_t_rd + TW'(1);
      if (r_cnt != '0) begin
        r_hold_dat <= r_q_dat[r_rd];
        r_hold_pc  <= r_q_pc[r_rd];
      end
      if (w_redir) begin
        r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
        r_rd       <= '0;
        r_wr       <= '0;
        r_cnt      <= '0;
        if (bus.redirect_pc[1:0] != 2'b00) r_mis <= 1'b1;
      end else begin
        if (w_acc)  r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_keep) r_wr <= r_wr + PW'(1);
        if (w_pop)  r_rd <= r_rd + PW'(1);
        r_cnt <= r_cnt + w_keep_c - w_pop_c;
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counters and pointers above.
  always_ff @(posedge clk) begin
    if (!rst && w_acc) r_tag[r_t_wr] <= r_fetch_pc;
    if (!rst && w_keep) begin
      r_q_dat[r_wr] <= bus.imem_rsp_data;
      r_q_pc[r_wr]  <= r_tag[r_t_rd];
    end
  end

  assign bus.imem_req_valid = w_req_vld;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.inst_valid     = (r_cnt != '0);
  assign bus.inst_data      = (r_cnt != '0) ? r_q_dat[r_rd] : r_hold_dat;
  assign bus.inst_pc        = (r_cnt != '0) ? r_q_pc[r_rd]  : r_hold_pc;
  assign bus.misalign_err   = r_mis;
endmodule
